answer_checker: RTL and testbench
=================================

// Module: answer_checker
// PURPOSE
// - Upstream feeder of the level selector (level_choose).
// - Captures the pattern shown for the current round.
// - Compares the player's button presses against that pattern, one symbol at a time.
// - Emits a single-cycle ans (all correct) or wrong (mismatch/timeout) pulse.
// - Sequence length scales with the current level: more symbols at higher levels.
// PARAMETERS
// - MAX_LEN      8     max symbols per round; len = min(2*(level+1), MAX_LEN)
// - SYM_W        2     bits per symbol (4 buttons)
// - TIMEOUT_CYC  1000  idle cycles allowed between presses (only with ANSWER_TIMEOUT_EN)
// PORTS
// - clk        in   1                clock, all logic rising-edge
// - reset      in   1                asynchronous, active-high; clears all state
// - start      in   1                pulse: latch pattern+level, begin a round
// - pattern    in   MAX_LEN*SYM_W    symbol i = pattern[i*SYM_W +: SYM_W]; i=0 is pressed first
// - level      in   2                current level from level_choose, sampled on start
// - btn_valid  in   1                one-cycle strobe per debounced press
// - btn_sym    in   SYM_W            pressed symbol, valid with btn_valid
// - busy       out  1                high in COLLECT
// - ans        out  1                one-cycle pulse: full sequence matched
// - wrong      out  1                one-cycle pulse: mismatch (or timeout)
// - progress   out  $clog2(MAX_LEN+1)  count of correct symbols so far this round
// BEHAVIOUR
// - One clock, async active-high reset.
// - Reset values: busy=0, ans=0, wrong=0, progress=0, state=IDLE.
// - Reset mid-round aborts the round; no pulse is emitted.
// - FSM states: IDLE, COLLECT, RESULT.
// - IDLE:
//   - On start: register pattern, len, idx=0, progress=0.
//   - Next cycle -> COLLECT.
//   - btn_valid without start is ignored.
// - COLLECT, btn_valid with btn_sym == pat[idx]:
//   - If idx == len-1 -> RESULT with ok=1.
//   - Otherwise idx++, progress++.
// - COLLECT, btn_valid with btn_sym != pat[idx]:
//   - -> RESULT with ok=0.
//   - progress holds its value.
// - RESULT:
//   - Lasts exactly one cycle: ans=ok, wrong=!ok.
//   - On a match, progress=len in the same cycle.
//   - Then -> IDLE; progress holds until the next start.
// - Latency: ans/wrong is high in the cycle after the deciding btn_valid edge.
// - start in COLLECT or RESULT:
//   - Aborts the current round without a pulse.
//   - Re-latches and restarts (-> COLLECT next cycle).
// - start and btn_valid in the same cycle: start wins, the press is discarded.
// - btn_valid in RESULT is discarded.
// - len arithmetic: 2*(level+1) is computed 4 bits wide, then clipped to MAX_LEN.
//   - level=3 with MAX_LEN=8 gives len=8.
//   - MAX_LEN=6 clips level=3 to len=6.
// - ans and wrong are never high together.
// CONFIGURATION
// - Macro ANSWER_TIMEOUT_EN.
// - Defined:
//   - Inter-press counter is cleared on entry to COLLECT and on each btn_valid.
//   - Reaching TIMEOUT_CYC in COLLECT -> RESULT with ok=0 (wrong pulse).
//   - btn_valid in the expiry cycle takes priority over the timeout.
// - Undefined:
//   - No counter is built; COLLECT waits indefinitely.
//   - The TIMEOUT_CYC parameter is unused.
// TESTING
// - Level 0, pattern {1,3}: start, then press 1, 3.
//   - Expect ans high exactly 1 cycle after the 2nd press; progress=2; wrong never high.
// - Level 1, pattern {0,1,2,3}: press 0, 1, 0.
//   - Expect wrong pulse 1 cycle after the 3rd press; progress=2; no ans.
// - Level 3, MAX_LEN=8: press all 8 symbols correctly.
//   - Expect ans after the 8th press, not earlier.
//   - After the 7th press, busy=1 and progress=7.
// - start mid-round after 2 correct presses:
//   - Expect no pulse; progress=0; busy stays 1; the new pattern is checked from idx 0.
// - reset asserted asynchronously mid-COLLECT:
//   - Expect busy, ans, wrong, progress = 0 immediately.
//   - Expect presses ignored until the next start.
// - With ANSWER_TIMEOUT_EN, TIMEOUT_CYC=20: start, then no press.
//   - Expect the wrong pulse at exactly 20 cycles after COLLECT entry.
//   - Expect no timeout when pressing every 19 cycles.

Source files
------------

// File: rtl/answer_checker.sv
// Answer checker: latches a round's pattern and level, compares button presses against it
// symbol by symbol, and pulses ans on a full match or wrong on a mismatch.
// Optional inter-press timeout is built when the ANSWER_TIMEOUT_EN macro is defined.
module answer_checker #(
   parameter int unsigned MAX_LEN     = 8,
   parameter int unsigned SYM_W       = 2,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [MAX_LEN*SYM_W-1:0]        pattern,
   input  logic [1:0]                      level,
   input  logic                            btn_valid,
   input  logic [SYM_W-1:0]                btn_sym,
   output logic                            busy,
   output logic                            ans,
   output logic                            wrong,
   output logic [$clog2(MAX_LEN+1)-1:0]    progress
);

   localparam int unsigned PROG_W = $clog2(MAX_LEN + 1);
   localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   // Reject configurations that cannot hold a sequence or a timeout window.
   if (MAX_LEN < 1 || SYM_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("answer_checker: MAX_LEN, SYM_W and TIMEOUT_CYC must all be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      RESULT  = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [MAX_LEN-1:0][SYM_W-1:0]   pat_q, pat_d;
   logic [PROG_W-1:0]               len_q, len_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [PROG_W-1:0]               prog_d;
   logic                            busy_d, ans_d, wrong_d;
   logic [3:0]                      len_raw;
   logic [PROG_W-1:0]               len_calc;
   logic                            sym_match;
   logic                            last_sym;

   // Sequence length: 2*(level+1) in 4 bits, clipped to the pattern capacity.
   always_comb begin
      len_raw = {1'b0, level, 1'b0} + 4'd2;
      if (32'(len_raw) > MAX_LEN) begin
         len_calc = PROG_W'(MAX_LEN);
      end else begin
         len_calc = PROG_W'(len_raw);
      end
   end

   assign sym_match = (btn_sym == pat_q[idx_q]);
   assign last_sym  = (PROG_W'(idx_q) == (len_q - PROG_W'(1)));

`ifdef ANSWER_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             tmr_expire;

   assign tmr_expire = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      idx_d   = idx_q;
      prog_d  = progress;
      ans_d   = 1'b0;
      wrong_d = 1'b0;
`ifdef ANSWER_TIMEOUT_EN
      tmr_d   = tmr_q;
`endif

      if (start) begin
         // A start in any state aborts silently and re-latches the round.
         state_d = COLLECT;
         pat_d   = pattern;
         len_d   = len_calc;
         idx_d   = '0;
         prog_d  = '0;
`ifdef ANSWER_TIMEOUT_EN
         tmr_d   = '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            COLLECT: begin
               if (btn_valid) begin
`ifdef ANSWER_TIMEOUT_EN
                  tmr_d = '0;
`endif
                  if (!sym_match) begin
                     state_d = RESULT;
                     wrong_d = 1'b1;
                  end else if (last_sym) begin
                     state_d = RESULT;
                     ans_d   = 1'b1;
                     prog_d  = len_q;
                  end else begin
                     idx_d  = idx_q + IDX_W'(1);
                     prog_d = progress + PROG_W'(1);
                  end
               end
`ifdef ANSWER_TIMEOUT_EN
               else if (tmr_expire) begin
                  state_d = RESULT;
                  wrong_d = 1'b1;
               end else begin
                  tmr_d = tmr_q + TMR_W'(1);
               end
`endif
            end
            RESULT: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d == COLLECT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         pat_q    <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         progress <= '0;
         busy     <= 1'b0;
         ans      <= 1'b0;
         wrong    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pat_q    <= pat_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         progress <= prog_d;
         busy     <= busy_d;
         ans      <= ans_d;
         wrong    <= wrong_d;
      end
   end

`ifdef ANSWER_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_d;
      end
   end
`endif

endmodule

// File: tb/tb_answer_checker.sv
// Directed self-checking bench for answer_checker; timeout cases run only when
// ANSWER_TIMEOUT_EN is defined (TIMEOUT_CYC set to 20 here).
module tb_answer_checker;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned SYM_W   = 2;
   localparam int unsigned PROG_W  = $clog2(MAX_LEN + 1);

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       start;
   logic [MAX_LEN*SYM_W-1:0]   pattern;
   logic [1:0]                 level;
   logic                       btn_valid;
   logic [SYM_W-1:0]           btn_sym;
   logic                       busy;
   logic                       ans;
   logic                       wrong;
   logic [PROG_W-1:0]          progress;

   int n_checks = 0;
   int n_fail   = 0;
   int both_cnt = 0;

   answer_checker #(
      .MAX_LEN     (MAX_LEN),
      .SYM_W       (SYM_W),
      .TIMEOUT_CYC (20)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pattern   (pattern),
      .level     (level),
      .btn_valid (btn_valid),
      .btn_sym   (btn_sym),
      .busy      (busy),
      .ans       (ans),
      .wrong     (wrong),
      .progress  (progress)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ans && wrong) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Packs up to eight symbols; element 0 is pressed first.
   function automatic logic [MAX_LEN*SYM_W-1:0] mk_pat(input int s0, s1, s2, s3, s4, s5, s6, s7);
      logic [MAX_LEN*SYM_W-1:0] p;
      int s [8];
      s = '{s0, s1, s2, s3, s4, s5, s6, s7};
      p = '0;
      for (int i = 0; i < 8; i++) p[i*SYM_W +: SYM_W] = SYM_W'(s[i]);
      return p;
   endfunction

   task automatic do_start(input logic [1:0] lvl, input logic [MAX_LEN*SYM_W-1:0] pat);
      @(negedge clk);
      start   = 1'b1;
      level   = lvl;
      pattern = pat;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic press(input int sym);
      @(negedge clk);
      btn_valid = 1'b1;
      btn_sym   = SYM_W'(sym);
      @(negedge clk);
      btn_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seq [8];
      reset = 1'b1; start = 1'b0; pattern = '0; level = '0; btn_valid = 1'b0; btn_sym = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_ans", 32'(ans), 0);
      check("rst_wrong", 32'(wrong), 0);
      check("rst_progress", 32'(progress), 0);
      reset = 1'b0;

      // Presses in IDLE are ignored.
      press(1);
      check("idle_busy", 32'(busy), 0);
      check("idle_wrong", 32'(wrong), 0);

      // Level 0, {1,3}: full match.
      do_start(2'd0, mk_pat(1, 3, 0, 0, 0, 0, 0, 0));
      check("l0_busy", 32'(busy), 1);
      check("l0_prog0", 32'(progress), 0);
      press(1);
      check("l0_prog1", 32'(progress), 1);
      check("l0_ans_early", 32'(ans), 0);
      press(3);
      check("l0_ans", 32'(ans), 1);
      check("l0_wrong", 32'(wrong), 0);
      check("l0_prog2", 32'(progress), 2);
      check("l0_busy_res", 32'(busy), 0);
      @(negedge clk);
      check("l0_ans_off", 32'(ans), 0);
      check("l0_prog_hold", 32'(progress), 2);

      // Level 1, {0,1,2,3}: third press mismatches.
      do_start(2'd1, mk_pat(0, 1, 2, 3, 0, 0, 0, 0));
      press(0);
      press(1);
      check("l1_prog", 32'(progress), 2);
      press(0);
      check("l1_wrong", 32'(wrong), 1);
      check("l1_ans", 32'(ans), 0);
      check("l1_prog_hold", 32'(progress), 2);
      @(negedge clk);
      check("l1_wrong_off", 32'(wrong), 0);

      // Level 3: eight symbols, ans only after the last.
      seq = '{3, 2, 1, 0, 0, 1, 2, 3};
      do_start(2'd3, mk_pat(3, 2, 1, 0, 0, 1, 2, 3));
      for (int i = 0; i < 7; i++) begin
         press(seq[i]);
         check("l3_no_ans", 32'(ans), 0);
      end
      check("l3_busy7", 32'(busy), 1);
      check("l3_prog7", 32'(progress), 7);
      press(seq[7]);
      check("l3_ans", 32'(ans), 1);
      check("l3_prog8", 32'(progress), 8);

      // Restart mid-round after two correct presses.
      do_start(2'd1, mk_pat(2, 2, 1, 1, 0, 0, 0, 0));
      press(2);
      press(2);
      do_start(2'd1, mk_pat(1, 0, 3, 2, 0, 0, 0, 0));
      check("rs_ans", 32'(ans), 0);
      check("rs_wrong", 32'(wrong), 0);
      check("rs_prog", 32'(progress), 0);
      check("rs_busy", 32'(busy), 1);
      press(1);
      press(0);
      press(3);
      check("rs_prog3", 32'(progress), 3);
      press(2);
      check("rs_ans_done", 32'(ans), 1);
      check("rs_prog4", 32'(progress), 4);

      // start and btn_valid together: press is discarded.
      @(negedge clk);
      start = 1'b1; level = 2'd0; pattern = mk_pat(2, 1, 0, 0, 0, 0, 0, 0);
      btn_valid = 1'b1; btn_sym = 2'd3;
      @(negedge clk);
      start = 1'b0; btn_valid = 1'b0;
      check("sb_wrong", 32'(wrong), 0);
      check("sb_prog", 32'(progress), 0);
      check("sb_busy", 32'(busy), 1);
      press(2);
      check("sb_prog1", 32'(progress), 1);

      // Asynchronous reset mid-COLLECT.
      do_start(2'd1, mk_pat(0, 1, 2, 3, 0, 0, 0, 0));
      press(0);
      #2 reset = 1'b1;
      #1;
      check("ar_busy", 32'(busy), 0);
      check("ar_ans", 32'(ans), 0);
      check("ar_wrong", 32'(wrong), 0);
      check("ar_prog", 32'(progress), 0);
      @(negedge clk);
      reset = 1'b0;
      press(1);
      press(2);
      check("ar_ign_busy", 32'(busy), 0);
      check("ar_ign_prog", 32'(progress), 0);
      check("ar_ign_ans", 32'(ans), 0);
      check("ar_ign_wrong", 32'(wrong), 0);

`ifdef ANSWER_TIMEOUT_EN
      // No press: wrong exactly 20 cycles after COLLECT entry.
      do_start(2'd0, mk_pat(1, 3, 0, 0, 0, 0, 0, 0));
      for (int i = 1; i < 20; i++) begin
         @(negedge clk);
         check("to_early", 32'(wrong), 0);
      end
      @(negedge clk);
      check("to_wrong", 32'(wrong), 1);
      check("to_ans", 32'(ans), 0);

      // Pressing every 19 cycles never times out.
      do_start(2'd0, mk_pat(1, 3, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("to_gap", 32'(wrong), 0);
         end
         press(k == 0 ? 1 : 3);
      end
      check("to_slow_ans", 32'(ans), 1);
      check("to_slow_wrong", 32'(wrong), 0);
`endif

      check("ans_wrong_excl", 32'(both_cnt), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
